// File: rtl/lector_salida_transaccion.sv
// lector_salida_transaccion: round-robin drain of four blue FIFOs onto one valid/ready stream
// Ports: clk, reset (sync, active-high), Enable gates new pops; fifo_empty/fifo_data_p0..p3 from the
// transaction layer; pop_fifo_azules one-hot pop back to it; data_out/valid_out/ready_in/port_out
// output stream; word_count handshake counter; dest_error sticky mismatch; idle when nothing to do.
// Optional: define LECTOR_DEST_CHECK_EN to build the destination-field checker.
module lector_salida_transaccion #(
  parameter int DATA_W = 12,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Enable,
  input  logic [3:0]        fifo_empty,
  input  logic [DATA_W-1:0] fifo_data_p0,
  input  logic [DATA_W-1:0] fifo_data_p1,
  input  logic [DATA_W-1:0] fifo_data_p2,
  input  logic [DATA_W-1:0] fifo_data_p3,
  output logic [3:0]        pop_fifo_azules,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  input  logic              ready_in,
  output logic [1:0]        port_out,
  output logic [CNT_W-1:0]  word_count,
  output logic              dest_error,
  output logic              idle
);
  typedef enum logic [1:0] {IDLE, LEER, CAPTURA, ENVIO} state_t;
  state_t            state_q;
  logic [1:0]        ptr_q, sel_q, sel_d, port_q;
  logic [DATA_W-1:0] data_q, rd_data;
  logic              valid_q;
  logic [CNT_W-1:0]  cnt_q;
  // Scan from the highest offset down so the nearest non-empty port after ptr wins.
  always_comb begin
    sel_d = ptr_q;
    for (int k = 3; k >= 0; k--)
      if (!fifo_empty[ptr_q + 2'(k)]) sel_d = ptr_q + 2'(k);
  end
  assign rd_data = sel_q == 2'd0 ? fifo_data_p0 :
                   sel_q == 2'd1 ? fifo_data_p1 :
                   sel_q == 2'd2 ? fifo_data_p2 : fifo_data_p3;
  assign pop_fifo_azules = state_q == LEER ? 4'b0001 << sel_q : 4'b0000;
  assign idle       = state_q == IDLE && &fifo_empty;
  assign data_out   = data_q;
  assign valid_out  = valid_q;
  assign port_out   = port_q;
  assign word_count = cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      sel_q   <= 2'd0;
      port_q  <= 2'd0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (Enable && !(&fifo_empty)) begin
          sel_q   <= sel_d;
          state_q <= LEER;
        end
        LEER: state_q <= CAPTURA;
        CAPTURA: begin
          data_q  <= rd_data;
          port_q  <= sel_q;
          valid_q <= 1'b1;
          state_q <= ENVIO;
        end
        ENVIO: if (ready_in) begin
          valid_q <= 1'b0;
          cnt_q   <= cnt_q + CNT_W'(1);
          ptr_q   <= sel_q + 2'd1;
          state_q <= IDLE;
        end
      endcase
    end
  end
`ifdef LECTOR_DEST_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset) err_q <= 1'b0;
    else if (state_q == CAPTURA && rd_data[DATA_W-3 -: 2] != sel_q) err_q <= 1'b1;
  end
  assign dest_error = err_q;
`else
  assign dest_error = 1'b0;
`endif
endmodule

// File: tb/tb_lector_salida_transaccion.sv
// tb_lector_salida_transaccion: directed scoreboard bench for lector_salida_transaccion
module tb_lector_salida_transaccion;
`ifdef LECTOR_DEST_CHECK_EN
  localparam bit DCHK = 1'b1;
`else
  localparam bit DCHK = 1'b0;
`endif
  logic        clk = 1'b0, reset = 1'b1, en = 1'b0, ready = 1'b1;
  logic [3:0]  femp = 4'hF, pop;
  logic [11:0] fdata [4] = '{default: 12'h0};
  logic [11:0] data_out;
  logic        valid_out, dest_error, idle;
  logic [1:0]  port_out;
  logic [7:0]  word_count;
  logic [11:0] fq [4][$];
  logic [13:0] sb [$];
  logic [13:0] mon_e;
  int n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  lector_salida_transaccion dut (
    .clk(clk), .reset(reset), .Enable(en), .fifo_empty(femp),
    .fifo_data_p0(fdata[0]), .fifo_data_p1(fdata[1]), .fifo_data_p2(fdata[2]), .fifo_data_p3(fdata[3]),
    .pop_fifo_azules(pop), .data_out(data_out), .valid_out(valid_out), .ready_in(ready),
    .port_out(port_out), .word_count(word_count), .dest_error(dest_error), .idle(idle)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  // FIFO model: pop sampled mid-cycle, read data ready long before the capture edge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (pop[i] && fq[i].size() > 0) fdata[i] = fq[i].pop_front();
      femp[i] = fq[i].size() == 0;
    end
  end
  // Handshake monitor against the scoreboard, plus one-hot pop check every cycle.
  always begin
    @(negedge clk);
    #2;
    chk("pop_onehot", 32'($onehot0(pop)), 1);
    if (valid_out && ready) begin
      if (sb.size() == 0) chk("sb_unexpected", sb.size(), 1);
      else begin
        mon_e = sb.pop_front();
        chk("hs_data", data_out, mon_e[11:0]);
        chk("hs_port", port_out, mon_e[13:12]);
      end
    end
  end
  task automatic tick();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input int p, input logic [11:0] w);
    fq[p].push_back(w);
    sb.push_back({2'(p), w});
  endtask
  task automatic wait_pop(input string tag);
    int n;
    for (n = 0; n < 30 && pop == 4'b0; n++) tick();
    if (n == 30) chk(tag, pop, 1);
  endtask
  task automatic drain(input string tag);
    for (int n = 0; n < 80 && sb.size() > 0; n++) tick();
    chk(tag, sb.size(), 0);
  endtask
  initial begin
    int cyc, last, g;
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] c0;
    repeat (3) tick();
    reset = 1'b0;
    en = 1'b1;
    tick();
    chk("rst_pop", pop, 0);
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_port", port_out, 0);
    chk("rst_count", word_count, 0);
    chk("rst_derr", dest_error, 0);
    for (int i = 0; i < 20; i++) begin
      chk("empty_idle", idle, 1);
      chk("empty_nopop", pop, 0);
      tick();
    end
    push(2, 12'h2A5);
    wait_pop("t2_pop_timeout");
    chk("t2_pop", pop, 4'b0100);
    tick();
    chk("t2_pop_1cyc", pop, 0);
    tick();
    chk("t2_valid", valid_out, 1);
    chk("t2_data", data_out, 12'h2A5);
    chk("t2_port", port_out, 2);
    tick();
    chk("t2_count", word_count, 1);
    reset = 1'b1;
    en = 1'b0;
    tick();
    reset = 1'b0;
    push(0, 12'h0A1); push(1, 12'h1B2); push(2, 12'h2C3); push(3, 12'h3D4); push(0, 12'h0E5);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("en0_nopop", pop, 0);
    end
    chk("t3_count0", word_count, 0);
    en = 1'b1;
    g = 0;
    last = 0;
    for (cyc = 0; cyc < 60 && g < 5; cyc++) begin
      tick();
      if (pop != 4'b0) begin
        chk("t3_order", pop, 4'b0001 << order[g]);
        if (g > 0) chk("t3_gap", cyc - last, 4);
        last = cyc;
        g++;
      end
    end
    chk("t3_grants", g, 5);
    drain("t3_drain");
    chk("t3_count", word_count, 5);
    ready = 1'b0;
    push(1, 12'h155);
    push(2, 12'h266);
    for (int n = 0; n < 30 && !valid_out; n++) tick();
    chk("t4_valid_up", valid_out, 1);
    c0 = word_count;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t4_hold_valid", valid_out, 1);
      chk("t4_hold_data", data_out, 12'h155);
      chk("t4_nopop", pop, 0);
    end
    ready = 1'b1;
    tick();
    chk("t4_count_once", word_count, c0 + 8'd1);
    drain("t4_drain");
    chk("t5_derr_pre", dest_error, 0);
    push(3, 12'h100);
    drain("t5_drain");
    chk("t5_derr", dest_error, DCHK);
    repeat (5) tick();
    chk("t5_derr_sticky", dest_error, DCHK);
    push(0, 12'h077);
    wait_pop("t6_pop_timeout");
    tick();
    reset = 1'b1;
    sb.delete();
    tick();
    reset = 1'b0;
    chk("t6_valid", valid_out, 0);
    chk("t6_count", word_count, 0);
    chk("t6_data", data_out, 0);
    chk("t6_idle", idle, 1);
    chk("t6_derr", dest_error, 0);
    repeat (6) tick();
    chk("t6_no_output", valid_out, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
